// File: rtl/pdp8_core_mem_if.sv
// pdp8_core_mem_if: CPU <-> core memory bus.
//   master (CPU)   : drives address, write_data, write_enable, mem_load;
//                    receives read_data, mem_ready, busy.
//   slave  (memory): the mirror image.
interface pdp8_core_mem_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 12
);
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] write_data;
    logic              write_enable;
    logic              mem_load;
    logic [DATA_W-1:0] read_data;
    logic              mem_ready;
    logic              busy;

    modport master (
        output address, write_data, write_enable, mem_load,
        input  read_data, mem_ready, busy
    );

    modport slave (
        input  address, write_data, write_enable, mem_load,
        output read_data, mem_ready, busy
    );
endinterface

// File: rtl/pdp8_core_mem.sv
// pdp8_core_mem: 2^ADDR_W x DATA_W word store emulating core-memory timing.
//   clk, nrst        : clock, async active-low reset
//   bus (slave)      : CPU request lines (level), registered read_data,
//                      one-cycle mem_ready strobe, busy (state != IDLE)
//   ld_en/addr/data  : preload write port, honoured only while IDLE
// Each access spends LATENCY cycles in ACCESS, one RESPOND cycle with
// mem_ready high, RESTORE_CYCLES of recovery after reads, then waits in
// RELEASE until both request lines drop so a held request is not re-taken.
module pdp8_core_mem #(
    parameter int ADDR_W         = 12,
    parameter int DATA_W         = 12,
    parameter int LATENCY        = 2,
    parameter int RESTORE_CYCLES = 1
) (
    input  logic              clk,
    input  logic              nrst,
    pdp8_core_mem_if.slave    bus,
    input  logic              ld_en,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);
    localparam logic [3:0] RST_M1 = 4'(RESTORE_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, ACCESS, RESPOND, RESTORE, RELEASE} state_t;

    state_t            state, state_n;
    logic [3:0]        cnt, cnt_n;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              wr_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic req, accept, commit;
    assign req    = bus.mem_load | bus.write_enable;
    // Loader has priority over a CPU request in the same IDLE cycle.
    assign accept = (state == IDLE) && !ld_en && req;
    assign commit = (state == ACCESS) && (cnt == 4'd0);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE: if (accept) begin
                state_n = ACCESS;
                cnt_n   = LAT_M1;
            end
            ACCESS: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                    else             state_n = RESPOND;
            RESPOND: if (!wr_q && RESTORE_CYCLES > 0) begin
                state_n = RESTORE;
                cnt_n   = RST_M1;
            end else begin
                state_n = RELEASE;
            end
            RESTORE: if (cnt != 4'd0) cnt_n = cnt - 4'd1;
                     else             state_n = RELEASE;
            RELEASE: if (!req) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state         <= IDLE;
            cnt           <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wr_q          <= 1'b0;
            bus.read_data <= '0;
            bus.mem_ready <= 1'b0;
            bus.busy      <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q  <= bus.address;
                wdata_q <= bus.write_data;
                // Both lines high counts as a write.
                wr_q    <= bus.write_enable;
            end
            if (commit && !wr_q) bus.read_data <= mem[addr_q];
            // Outputs follow the next state so they are registered yet
            // line up with the state they describe.
            bus.mem_ready <= (state_n == RESPOND);
            bus.busy      <= (state_n != IDLE);
        end
    end

    // Storage is never cleared by reset. A reset during ACCESS forces
    // state to IDLE before the commit edge, so the write is dropped.
    always_ff @(posedge clk) begin
        if (state == IDLE && ld_en) mem[ld_addr] <= ld_data;
        else if (commit && wr_q)    mem[addr_q]  <= wdata_q;
    end
endmodule

// File: tb/tb_pdp8_core_mem.sv
module tb_pdp8_core_mem;
    logic        clk = 1'b0;
    logic        nrst;
    logic        ld_en;
    logic [11:0] ld_addr, ld_data;

    always #5 clk = ~clk;

    pdp8_core_mem_if #(.ADDR_W(12), .DATA_W(12)) bus ();

    pdp8_core_mem #(.ADDR_W(12), .DATA_W(12), .LATENCY(2), .RESTORE_CYCLES(1)) dut (
        .clk     (clk),
        .nrst    (nrst),
        .bus     (bus),
        .ld_en   (ld_en),
        .ld_addr (ld_addr),
        .ld_data (ld_data)
    );

    int          checks = 0;
    int          errors = 0;
    int          pulses = 0;
    logic [11:0] exp_q[$];
    logic [11:0] exp_rd;
    logic [11:0] model [4096];

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
        end
    endtask

    // Scoreboard: each mem_ready pulse consumes one expected read_data.
    always @(negedge clk) begin
        if (nrst === 1'b1 && bus.mem_ready === 1'b1) begin
            pulses++;
            chk("ready_expected", 12'(exp_q.size() != 0), 12'd1);
            if (exp_q.size() != 0) chk("sb_read_data", bus.read_data, exp_q.pop_front());
        end
    end

    task automatic load(input logic [11:0] a, input logic [11:0] d);
        @(negedge clk);
        ld_en = 1'b1; ld_addr = a; ld_data = d;
        model[a] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_exp(input logic wr, input logic [11:0] a, input logic [11:0] d);
        if (wr) model[a] = d;
        else    exp_rd = model[a];
        exp_q.push_back(exp_rd);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (bus.mem_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ready_timeout"}, 12'(n < 40), 12'd1);
    endtask

    task automatic release_bus(input string tag);
        int n = 0;
        bus.mem_load = 1'b0;
        bus.write_enable = 1'b0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.busy !== 1'b0 && n < 40);
        chk({tag, "_idle_timeout"}, 12'(n < 40), 12'd1);
    endtask

    task automatic access(input logic wr, input logic rd, input logic [11:0] a,
                          input logic [11:0] d, input string tag);
        int p0;
        @(negedge clk);
        bus.address = a; bus.write_data = d;
        bus.write_enable = wr; bus.mem_load = rd;
        p0 = pulses;
        push_exp(wr, a, d);
        wait_ready(tag);
        release_bus(tag);
        chk({tag, "_pulses"}, 12'(pulses - p0), 12'd1);
    endtask

    initial begin
        int p0;
        nrst = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        bus.address = '0; bus.write_data = '0;
        bus.write_enable = 1'b0; bus.mem_load = 1'b0;
        exp_rd = '0;
        repeat (2) @(negedge clk);
        chk("rst_ready", 12'(bus.mem_ready), 12'd0);
        chk("rst_busy", 12'(bus.busy), 12'd0);
        chk("rst_read_data", bus.read_data, 12'd0);
        nrst = 1'b1;

        load(12'o0200, 12'o7402);
        load(12'o0100, 12'o0001);
        load(12'o0300, 12'o3333);

        // Preload and read back with exact strobe timing; request held.
        @(negedge clk);
        bus.address = 12'o0200; bus.mem_load = 1'b1;
        push_exp(1'b0, 12'o0200, '0);
        for (int j = 0; j <= 5; j++) begin
            @(negedge clk);   // after edge T+j
            chk($sformatf("tim_ready_%0d", j), 12'(bus.mem_ready), 12'(j == 2));
            chk($sformatf("tim_busy_%0d", j), 12'(bus.busy), 12'd1);
        end
        chk("tim_read_data", bus.read_data, 12'o7402);
        bus.mem_load = 1'b0;
        @(negedge clk);
        chk("tim_idle_busy", 12'(bus.busy), 12'd0);

        // Top address write then read.
        access(1'b1, 1'b0, 12'o7777, 12'o1234, "top_wr");
        chk("top_wr_rd_hold", bus.read_data, 12'o7402);
        access(1'b0, 1'b1, 12'o7777, 12'o0000, "top_rd");
        chk("top_rd_data", bus.read_data, 12'o1234);

        // Both lines high is a write.
        access(1'b1, 1'b1, 12'o0050, 12'o0777, "both");
        chk("both_rd_hold", bus.read_data, 12'o1234);
        access(1'b0, 1'b1, 12'o0050, 12'o0000, "both_rb");
        chk("both_rb_data", bus.read_data, 12'o0777);

        // Held request: no re-accept until the lines drop.
        @(negedge clk);
        bus.address = 12'o0200; bus.mem_load = 1'b1;
        p0 = pulses;
        push_exp(1'b0, 12'o0200, '0);
        wait_ready("held1");
        for (int j = 0; j < 10; j++) begin
            @(negedge clk);
            chk("held_ready", 12'(bus.mem_ready), 12'd0);
            chk("held_busy", 12'(bus.busy), 12'd1);
        end
        bus.mem_load = 1'b0;
        @(negedge clk);
        chk("held_drop_busy", 12'(bus.busy), 12'd0);
        bus.mem_load = 1'b1;
        push_exp(1'b0, 12'o0200, '0);
        wait_ready("held2");
        release_bus("held2");
        chk("held_pulses", 12'(pulses - p0), 12'd2);

        // Reset during ACCESS of a write.
        @(negedge clk);
        bus.address = 12'o0100; bus.write_data = 12'o5555; bus.write_enable = 1'b1;
        @(negedge clk);
        chk("mid_busy", 12'(bus.busy), 12'd1);
        nrst = 1'b0;
        #1;
        chk("mid_rst_busy", 12'(bus.busy), 12'd0);
        chk("mid_rst_ready", 12'(bus.mem_ready), 12'd0);
        chk("mid_rst_read_data", bus.read_data, 12'd0);
        bus.write_enable = 1'b0;
        exp_rd = '0;
        @(negedge clk);
        nrst = 1'b1;
        access(1'b0, 1'b1, 12'o0100, 12'o0000, "mid_rb");
        chk("mid_rb_data", bus.read_data, 12'o0001);

        // Loader pulse while busy is ignored.
        @(negedge clk);
        bus.address = 12'o0200; bus.mem_load = 1'b1;
        push_exp(1'b0, 12'o0200, '0);
        @(negedge clk);
        chk("ldbusy_busy", 12'(bus.busy), 12'd1);
        ld_en = 1'b1; ld_addr = 12'o0300; ld_data = 12'o4444;
        @(negedge clk);
        ld_en = 1'b0;
        wait_ready("ldbusy");
        release_bus("ldbusy");
        access(1'b0, 1'b1, 12'o0300, 12'o0000, "ldbusy_rb");
        chk("ldbusy_rb_data", bus.read_data, 12'o3333);

        // Loader and CPU read of the same address in one IDLE cycle.
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 12'o0400; ld_data = 12'o0123;
        model[12'o0400] = 12'o0123;
        bus.address = 12'o0400; bus.mem_load = 1'b1;
        push_exp(1'b0, 12'o0400, '0);
        @(negedge clk);
        ld_en = 1'b0;
        chk("ldprio_busy", 12'(bus.busy), 12'd0);
        wait_ready("ldprio");
        release_bus("ldprio");
        chk("ldprio_data", bus.read_data, 12'o0123);

        repeat (3) @(negedge clk);
        chk("sb_drained", 12'(exp_q.size()), 12'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
